// File: rtl/spi_byte_link.sv
// rtl/spi_byte_link.sv - SPI slave byte front-end: pin sync, MOSI deserializer, MISO serializer with reply latch
module spi_byte_link #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       frame_start,
    output logic       frame_end,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_underrun
);

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, mosi_s, cs_s;

    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       first_flag;
    logic [7:0] tx_latch;
    logic       latch_full;
    logic [7:0] tx_shift;

    logic       cs_rise, cs_fall, sck_rise, sck_fall, load_next;
    logic [7:0] rx_byte;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // CS edges take precedence; an SCK edge landing in the same clk is dropped
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sck_rise  = cs_s & ~cs_rise & sck_s & ~sck_d;
    assign sck_fall  = cs_s & ~cs_rise & ~sck_s & sck_d;
    assign load_next = cs_rise | (sck_fall & byte_done);
    assign rx_byte   = {rx_shift, mosi_s};

    assign spi_miso = cs_s & tx_shift[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift    <= '0;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            first_flag  <= 1'b1;
            tx_latch    <= '0;
            latch_full  <= 1'b0;
            tx_shift    <= IDLE_BYTE;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_start <= cs_rise;
            frame_end   <= cs_fall;

            if (tx_wr) begin
                tx_latch   <= tx_data;
                latch_full <= 1'b1;
            end

            // A write coinciding with a load of an empty latch goes straight to the shifter
            if (load_next) begin
                if (latch_full) begin
                    tx_shift <= tx_latch;
                    if (!tx_wr)
                        latch_full <= 1'b0;
                end else if (tx_wr) begin
                    tx_shift   <= tx_data;
                    latch_full <= 1'b0;
                end else begin
                    tx_shift    <= IDLE_BYTE;
                    tx_underrun <= 1'b1;
                end
            end

            if (cs_rise || cs_fall) begin
                bit_cnt    <= '0;
                byte_done  <= 1'b0;
                first_flag <= 1'b1;
            end else if (sck_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data    <= rx_byte;
                    rx_valid   <= 1'b1;
                    rx_first   <= first_flag;
                    first_flag <= 1'b0;
                    byte_done  <= 1'b1;
                end
            end else if (sck_fall) begin
                if (byte_done)
                    byte_done <= 1'b0;
                else if (bit_cnt != 3'd0)
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

endmodule
